// File: rtl/dprs_be_if.sv
// Port bundle for dprs_be: synchronous read port (ce1/a1/q1), byte-lane write port
// (ce2/we2/be2/d2/a2) and the clear-in-progress flag.
interface dprs_be_if #(
    parameter int AW = 10,
    parameter int DW = 8,
    parameter int BL = (DW + 7) / 8
) ();
    logic          ce1;
    logic [AW-1:0] a1;
    logic [DW-1:0] q1;
    logic          ce2;
    logic          we2;
    logic [BL-1:0] be2;
    logic [DW-1:0] d2;
    logic [AW-1:0] a2;
    logic          busy;

    modport master (output ce1, a1, ce2, we2, be2, d2, a2, input q1, busy);
    modport slave  (input ce1, a1, ce2, we2, be2, d2, a2, output q1, busy);
endinterface

// File: rtl/dprs_be.sv
// Simple dual-port RAM with byte-lane writes, selectable read-during-write,
// optional output register and a post-reset clear sequencer sharing the write port.
module dprs_be #(
    parameter int            KB     = 1,
    parameter int            DW     = 8,
    parameter int            RDW    = 0,
    parameter int            OREG   = 0,
    parameter int            CLR    = 1,
    parameter logic [DW-1:0] CLRVAL = '0
) (
    input logic      clock,
    input logic      reset,
    dprs_be_if.slave bus
);
    localparam int          N    = KB * 1024;
    localparam int          AW   = $clog2(N);
    localparam int          BL   = (DW + 7) / 8;
    localparam logic [AW:0] LAST = (AW + 1)'(N - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          busy_i;
    logic          port_wr;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
    logic [DW-1:0] lane_mask;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] q_s1;

    logic [DW-1:0] mem [N];

    // Expand lane enables to a bit mask; the top lane is clipped to DW.
    for (genvar b = 0; b < BL; b++) begin : g_lane
        localparam int LO = 8 * b;
        localparam int HI = (LO + 7 < DW) ? LO + 7 : DW - 1;
        assign lane_mask[HI:LO] = {(HI - LO + 1){bus.be2[b]}};
    end

    assign busy_i   = reset || (state_q == S_CLEAR);
    assign port_wr  = !busy_i && bus.ce2 && !bus.we2;
    assign bus.busy = busy_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= (CLR != 0) ? S_CLEAR : S_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
                if (cnt_q == LAST)
                    state_d = S_READY;
            end
            default: ;
        endcase
    end

    // Clear sequencer owns the write port while it runs; port-2 writes are dropped.
    always_comb begin
        wen   = 1'b0;
        waddr = bus.a2;
        wdata = bus.d2;
        wmask = lane_mask;
        if (!reset && state_q == S_CLEAR) begin
            wen   = 1'b1;
            waddr = cnt_q[AW-1:0];
            wdata = CLRVAL;
            wmask = '1;
        end else if (port_wr) begin
            wen = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wen) begin
            for (int unsigned i = 0; i < DW; i++)
                if (wmask[i])
                    mem[waddr][i] <= wdata[i];
        end
    end

    always_comb begin
        rd_word = mem[bus.a1];
        if (RDW != 0 && port_wr && bus.a1 == bus.a2)
            rd_word = (rd_word & ~lane_mask) | (bus.d2 & lane_mask);
    end

    always_ff @(posedge clock) begin
        if (reset || busy_i) begin
            q_s1 <= '0;
        end else if (bus.ce1) begin
            q_s1 <= rd_word;
        end
    end

    if (OREG != 0) begin : g_oreg
        logic [DW-1:0] q_s2;
        logic          v1;
        // Output stage advances only when stage 1 took a read, so ce1=0 freezes both.
        always_ff @(posedge clock) begin
            if (reset || busy_i) begin
                q_s2 <= '0;
                v1   <= 1'b0;
            end else begin
                v1 <= bus.ce1;
                if (v1)
                    q_s2 <= q_s1;
            end
        end
        assign bus.q1 = q_s2;
    end else begin : g_noreg
        assign bus.q1 = q_s1;
    end
endmodule

// File: tb/tb_dprs_be.sv
// Randomised self-checking bench for dprs_be: two configurations run side by side
// against an array-based reference of the memory and its read latency.
module tb_dprs_be;
    localparam int N = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst [2];
    logic        s_ce1 [2];
    logic [9:0]  s_a1  [2];
    logic        s_ce2 [2];
    logic        s_we2 [2];
    logic [1:0]  s_be2 [2];
    logic [15:0] s_d2  [2];
    logic [9:0]  s_a2  [2];

    dprs_be_if #(.AW(10), .DW(8))  if0 ();
    dprs_be_if #(.AW(10), .DW(16)) if1 ();

    assign if0.ce1 = s_ce1[0];
    assign if0.a1  = s_a1[0];
    assign if0.ce2 = s_ce2[0];
    assign if0.we2 = s_we2[0];
    assign if0.be2 = s_be2[0][0];
    assign if0.d2  = s_d2[0][7:0];
    assign if0.a2  = s_a2[0];

    assign if1.ce1 = s_ce1[1];
    assign if1.a1  = s_a1[1];
    assign if1.ce2 = s_ce2[1];
    assign if1.we2 = s_we2[1];
    assign if1.be2 = s_be2[1];
    assign if1.d2  = s_d2[1];
    assign if1.a2  = s_a2[1];

    dprs_be #(.KB(1), .DW(8), .RDW(0), .OREG(0), .CLR(1), .CLRVAL(8'hA5)) u_dut0 (
        .clock (clk),
        .reset (s_rst[0]),
        .bus   (if0)
    );

    dprs_be #(.KB(1), .DW(16), .RDW(1), .OREG(1), .CLR(1), .CLRVAL(16'h0000)) u_dut1 (
        .clock (clk),
        .reset (s_rst[1]),
        .bus   (if1)
    );

    // Reference state
    logic [15:0] mm [2][N];
    int          clr_left [2];
    logic [15:0] st1 [2];
    logic [15:0] st2 [2];
    bit          v1m [2];
    logic [15:0] exp_q [2];
    bit          exp_busy [2];
    bit          bpre [2];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] get_q(input int d);
        return (d == 0) ? {8'h00, if0.q1} : if1.q1;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? if0.busy : if1.busy;
    endfunction

    function automatic bit rdw_of(input int d);  return d == 1; endfunction
    function automatic bit oreg_of(input int d); return d == 1; endfunction
    function automatic logic [15:0] clrval_of(input int d);
        return (d == 0) ? 16'h00A5 : 16'h0000;
    endfunction

    // One clock edge of the reference: clear, read (old or merged word), write.
    task automatic model_edge(input int d);
        logic [15:0] dmask, lmask, rd;
        bit wr;
        dmask = (d == 0) ? 16'h00FF : 16'hFFFF;
        lmask = {{8{s_be2[d][1]}}, {8{s_be2[d][0]}}} & dmask;
        wr    = s_ce2[d] && !s_we2[d];
        if (s_rst[d]) begin
            clr_left[d] = N;
            st1[d] = '0; st2[d] = '0; v1m[d] = 0;
        end else if (clr_left[d] > 0) begin
            mm[d][N - clr_left[d]] = clrval_of(d);
            clr_left[d]--;
            st1[d] = '0; st2[d] = '0; v1m[d] = 0;
        end else begin
            if (v1m[d]) st2[d] = st1[d];
            v1m[d] = s_ce1[d];
            if (s_ce1[d]) begin
                rd = mm[d][s_a1[d]];
                if (rdw_of(d) && wr && s_a1[d] == s_a2[d])
                    rd = (rd & ~lmask) | (s_d2[d] & lmask);
                st1[d] = rd & dmask;
            end
            if (wr)
                mm[d][s_a2[d]] = (mm[d][s_a2[d]] & ~lmask) | (s_d2[d] & lmask);
        end
        exp_q[d]    = oreg_of(d) ? st2[d] : st1[d];
        exp_busy[d] = s_rst[d] || clr_left[d] > 0;
    endtask

    task automatic tick();
        #1;
        bpre[0] = if0.busy;
        bpre[1] = if1.busy;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            model_edge(d);
            chk($sformatf("q1_dut%0d", d), {16'h0, get_q(d)}, {16'h0, exp_q[d]});
            chk($sformatf("busy_dut%0d", d), {31'h0, get_busy(d)}, {31'h0, exp_busy[d]});
        end
    endtask

    task automatic idle(input int d);
        s_ce1[d] = 0; s_a1[d] = '0;
        s_ce2[d] = 0; s_we2[d] = 1; s_be2[d] = '0; s_d2[d] = '0; s_a2[d] = '0;
    endtask

    task automatic rand_ops(input int d);
        s_ce1[d] = 1'($urandom_range(0, 1));
        s_a1[d]  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, N - 1)) : 10'($urandom_range(0, 15));
        s_ce2[d] = 1'($urandom_range(0, 1));
        s_we2[d] = ($urandom_range(0, 3) == 0);
        s_be2[d] = 2'($urandom_range(0, 3));
        s_d2[d]  = 16'($urandom);
        s_a2[d]  = ($urandom_range(0, 3) == 0) ? s_a1[d] : 10'($urandom_range(0, 15));
    endtask

    task automatic write1(input int d, input logic [9:0] a, input logic [15:0] v, input logic [1:0] be);
        idle(d);
        s_ce2[d] = 1; s_we2[d] = 0; s_a2[d] = a; s_d2[d] = v; s_be2[d] = be;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb0, nb1;
        nb0 = 0; nb1 = 0;
        for (int d = 0; d < 2; d++) begin
            idle(d);
            s_rst[d] = 1;
            clr_left[d] = 0; st1[d] = '0; st2[d] = '0; v1m[d] = 0;
        end

        // Reset for three cycles, then clear with writes and reads attempted throughout
        for (int k = 0; k < 3; k++) begin
            tick();
            nb0 += int'(bpre[0]); nb1 += int'(bpre[1]);
        end
        s_rst[0] = 0; s_rst[1] = 0;
        for (int k = 0; k < 1100 && (if0.busy === 1'b1 || if1.busy === 1'b1); k++) begin
            write1(0, 10'd3, 16'h0077, 2'b01);
            s_ce1[0] = 1; s_a1[0] = 10'($urandom_range(0, N - 1));
            rand_ops(1);
            tick();
            nb0 += int'(bpre[0]); nb1 += int'(bpre[1]);
            if (if0.busy === 1'b1) chk("q1_zero_busy", {16'h0, get_q(0)}, 32'h0);
        end
        chk("busy_cycles_dut0", nb0, 3 + N);
        chk("busy_cycles_dut1", nb1, 3 + N);
        chk("clear_done", {31'h0, if0.busy}, 32'h0);
        idle(0); idle(1);

        // Clear contents, including the word targeted while busy
        begin
            logic [9:0] addrs [4];
            addrs = '{10'd0, 10'd511, 10'd1023, 10'd3};
            foreach (addrs[i]) begin
                s_ce1[0] = 1; s_a1[0] = addrs[i];
                tick();
                chk($sformatf("clr_rd_%0d", addrs[i]), {16'h0, get_q(0)}, 32'hA5);
            end
            idle(0);
        end

        // Byte lanes on the 16-bit instance
        write1(1, 10'd5, 16'h1234, 2'b10); tick();
        write1(1, 10'd5, 16'hFFCD, 2'b01); tick();
        idle(1); s_ce1[1] = 1; s_a1[1] = 10'd5; tick();
        idle(1); tick();
        chk("byte_lanes", {16'h0, get_q(1)}, 32'h12CD);
        write1(1, 10'd5, 16'hFFFF, 2'b00); tick();
        idle(1); s_ce1[1] = 1; s_a1[1] = 10'd5; tick();
        idle(1); tick();
        chk("be_zero", {16'h0, get_q(1)}, 32'h12CD);

        // Read-during-write on the same address
        write1(0, 10'd7, 16'h0011, 2'b11);
        write1(1, 10'd7, 16'h0011, 2'b11);
        tick();
        for (int d = 0; d < 2; d++) begin
            write1(d, 10'd7, 16'h0022, 2'b11);
            s_ce1[d] = 1; s_a1[d] = 10'd7;
        end
        tick();
        chk("rdw_old_dut0", {16'h0, get_q(0)}, 32'h11);
        chk("oreg_lat1", {16'h0, get_q(1)}, 32'h12CD);
        idle(0); idle(1);
        tick();
        chk("rdw_new_dut1", {16'h0, get_q(1)}, 32'h22);
        s_ce1[0] = 1; s_a1[0] = 10'd7; s_ce1[1] = 1; s_a1[1] = 10'd7;
        tick();
        chk("reread_dut0", {16'h0, get_q(0)}, 32'h22);
        idle(0); idle(1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("hold_dut0", {16'h0, get_q(0)}, 32'h22);
            chk("hold_dut1", {16'h0, get_q(1)}, 32'h22);
        end

        // Random traffic, clustered addresses to provoke collisions
        for (int k = 0; k < 3000; k++) begin
            rand_ops(0);
            rand_ops(1);
            tick();
        end
        idle(0); idle(1);

        // Reset in READY (dut0) and reset mid-clear (dut1)
        write1(1, 10'd9, 16'hBEEF, 2'b11); tick();
        idle(1);
        s_rst[0] = 1; s_rst[1] = 1;
        tick(); tick();
        s_rst[0] = 0; s_rst[1] = 0;
        for (int k = 0; k < 500; k++) tick();
        chk("midclear_busy", {31'h0, if1.busy}, 32'h1);
        s_rst[1] = 1;
        tick(); tick();
        chk("midclear_rst_busy", {31'h0, if1.busy}, 32'h1);
        s_rst[1] = 0;
        nb1 = 0;
        for (int k = 0; k < 1100 && if1.busy === 1'b1; k++) begin
            tick();
            nb1 += int'(bpre[1]);
        end
        chk("restart_cycles", nb1, N);
        s_ce1[0] = 1; s_a1[0] = 10'd3; s_ce1[1] = 1; s_a1[1] = 10'd9;
        tick();
        chk("reclear_dut0", {16'h0, get_q(0)}, 32'hA5);
        idle(0); idle(1);
        tick();
        chk("reclear_dut1", {16'h0, get_q(1)}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dprs_be.md
Name: dprs_be

Overview:
- Parametrised successor to the simple dual-port RAM.
- One synchronous read port and one synchronous write port.
- Adds: byte-lane write enables, selectable read-during-write behaviour, optional output pipeline register, synchronous output reset, and a post-reset memory-clear sequencer with a busy flag.
- Used for video/char RAM and system RAM in the core, where a clean memory state after reset is required.

Parameters:
- KB, 1, depth in KiB; depth N = KB*1024 words, address width AW = $clog2(N).
- DW, 8, data width in bits; lane count BL = (DW+7)/8; the last lane covers the remaining bits if DW is not a multiple of 8.
- RDW, 0, read-during-write on the same address: 0 = old data, 1 = new data, forwarded per lane.
- OREG, 0, 1 adds an output register stage, giving read latency 2.
- CLR, 1, 1 enables the post-reset clear sequencer; 0 disables it.
- CLRVAL, 0, DW-bit value written to every word during clear.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ce1  in  1  read port enable.
- a1  in  AW  read address.
- q1  out  DW  read data (registered).
- ce2  in  1  write port enable.
- we2  in  1  write enable, active-low: a write occurs when ce2=1 and we2=0.
- be2  in  BL  byte-lane enables, active-high; lane i covers d2[8i+7:8i], clipped to DW.
- d2  in  DW  write data.
- a2  in  AW  write address.
- busy  out  1  high while in reset or while clearing; port 2 writes are ignored while busy.

Behaviour:
- Reset:
  - While reset=1: q1 <= 0; the OREG stage <= 0; busy = 1; FSM <= CLEAR (CLR=1) or READY (CLR=0); clear counter <= 0.
  - Memory contents are not touched on the reset cycles themselves.
- FSM, state CLEAR:
  - Each cycle: mem[cnt] <= CLRVAL; cnt <= cnt+1.
  - When cnt==N-1: perform the last write, then go to READY.
  - busy is high for every reset cycle plus exactly N cycles after reset falls. It falls on the first READY cycle.
- FSM, state READY:
  - busy = 0.
  - Write: if ce2 && !we2, then for each lane i with be2[i]=1, mem[a2] lane i <= d2 lane i. Lanes with be2[i]=0 keep their value.
  - be2 == 0 means no change.
- Read path:
  - If ce1=1 and not busy: q1 <= mem[a1], visible 1 cycle later (OREG=0) or 2 cycles later (OREG=1).
  - ce1=0: q1 holds its value; with OREG=1 the output stage also holds.
  - While busy: q1 is forced to 0 and reads are ignored.
- Read-during-write (ce1, ce2, !we2, a1==a2, not busy):
  - RDW=0: q1 returns the pre-write word.
  - RDW=1: q1 returns the merged word. Enabled lanes take d2; disabled lanes take the old data.
  - Different addresses: no interaction.
- Port-2 writes while busy are dropped silently; the clear sequence has priority.
- Reset asserted mid-clear: counter back to 0, sequence restarts from address 0 after reset falls. busy stays high throughout.
- Reset in READY: q1 <= 0; memory is re-cleared if CLR=1, otherwise it retains its contents.
- Counter is AW+1 bits wide internally, so the terminal compare never wraps. Addresses outside the array cannot occur, because AW is exact.
- Must infer block RAM for the memory: one read and one write per cycle. The clear sequencer uses the write port through a mux.

Test Plan:
- Clear timing:
  - Config: KB=1, DW=8, CLR=1, CLRVAL=8'hA5.
  - Stimulus: pulse reset for 3 cycles; after busy falls, read addr 0, 511 and 1023.
  - Required: busy high for 3+1024 cycles; every read = A5; q1=0 while busy.
- Byte lanes:
  - Config: DW=16, CLRVAL=0.
  - Stimulus: write d2=16'h1234, be2=2'b10 to addr 5; then d2=16'hFFCD, be2=2'b01 to addr 5; read addr 5.
  - Required: 16'h12CD. A write with be2=0 leaves the word unchanged.
- RDW modes:
  - Setup: mem[7]=8'h11.
  - Stimulus: same cycle, write 8'h22 to addr 7 and read addr 7.
  - Required: q1=11 with RDW=0, q1=22 with RDW=1; the next read of addr 7 returns 22 in both modes.
- Latency:
  - OREG=0: data appears 1 cycle after the ce1 edge.
  - OREG=1: data appears 2 cycles after the ce1 edge.
  - ce1=0 for 4 cycles: q1 holds.
- Writes during busy:
  - Stimulus: issue a write of 8'h77 to addr 3 while clearing.
  - Required: addr 3 reads CLRVAL afterwards.
- Reset mid-clear:
  - Stimulus: assert reset 500 cycles into the clear.
  - Required: busy stays high; a full N-cycle clear restarts; a word written before the first reset reads CLRVAL.
